// File: rtl/bit_deserializer.sv
// bit_deserializer: LSB-first serial-to-parallel word assembler feeding an output FIFO
// Ports:
//   clock, reset           single clock, synchronous active-high reset
//   in_valid, in_bit       serial input bit and its qualifier
//   flush                  push the partial word (zero-padded) when one is pending
//   out_data, out_valid    head-of-FIFO word, FIFO not empty
//   out_ready              consumer accepts head word
//   out_parity             XOR of head word (stored at push) when BIT_DESERIALIZER_PARITY_EN, else 0
//   overflow               sticky, set when a word is dropped on a full FIFO
// Optional feature macro: BIT_DESERIALIZER_PARITY_EN
module bit_deserializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr, word;
  logic [AW:0] wp, rp;
  logic push, pop, full, empty, wr;
`ifdef BIT_DESERIALIZER_PARITY_EN
  logic [WIDTH:0] mem [DEPTH];
  logic [WIDTH:0] entry;
  assign entry = {^word, word};
  assign out_parity = !empty && mem[rp[AW-1:0]][WIDTH];
`else
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] entry;
  assign entry = word;
  assign out_parity = 1'b0;
`endif
  // word already includes the current bit so a flush or final bit pushes it in the same edge
  always_comb begin
    word = in_valid ? sr | (WIDTH'(in_bit) << cnt) : sr;
    push = (in_valid && cnt == LAST) || (flush && (in_valid || cnt != '0));
    empty = wp == rp;
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    pop = !empty && out_ready;
    wr = push && (!full || pop);
  end
  assign out_valid = !empty;
  assign out_data = empty ? '0 : mem[rp[AW-1:0]][WIDTH-1:0];
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      sr <= '0;
      wp <= '0;
      rp <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        cnt <= '0;
        sr <= '0;
      end else if (in_valid) begin
        cnt <= cnt + CW'(1);
        sr <= word;
      end
      if (wr) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
      if (push && !wr) overflow <= 1'b1;
    end
  end
  // on a full FIFO with a pop, the write slot is the head being popped this edge
  always_ff @(posedge clock)
    if (!reset && wr) mem[wp[AW-1:0]] <= entry;
endmodule
